// File: rtl/mem_arb.sv
// Arbitrates one single-port memory between instruction fetch (i_) and load/store (d_), data first with fetch starvation guard.
// Latency: req sampled at N -> mem access N+1..N+MEM_LAT -> ack at N+MEM_LAT+1; requests are held (level) until ack.
module mem_arb #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam int              SC_W       = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [3:0]      LAT_INIT   = 4'(MEM_LAT - 1);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  logic [1:0]      state;
  logic [3:0]      lat_cnt;
  logic [SC_W-1:0] starve_cnt;
  req_t            req_q;
  req_t            sel_req;
  logic            grant_d;
  logic            any_req;

  always_comb begin
    any_req = i_req | d_req;
    grant_d = d_req & ~(i_req & (starve_cnt == STARVE_LIM));
    sel_req = '0;
    if (grant_d) begin
      sel_req.we    = d_we;
      sel_req.addr  = d_addr;
      sel_req.wdata = d_wdata;
    end else begin
      sel_req.addr  = i_addr;
    end
  end

  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      req_q      <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      owner      <= 1'b0;
    end else begin
      i_ack  <= 1'b0;
      d_ack  <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_req) starve_cnt <= '0;
          if (any_req) begin
            state   <= ACCESS;
            busy    <= 1'b1;
            owner   <= grant_d;
            mem_en  <= 1'b1;
            mem_we  <= sel_req.we;
            req_q   <= sel_req;
            lat_cnt <= LAT_INIT;
            // A fetch grant resets the starvation window; a data grant over a waiting fetch extends it.
            if (!grant_d)
              starve_cnt <= '0;
            else if (i_req && starve_cnt != STARVE_LIM)
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ACCESS: begin
          if (lat_cnt == '0) begin
            state  <= DONE;
            mem_en <= 1'b0;
            if (owner) begin
              d_ack <= 1'b1;
              if (!req_q.we) d_rdata <= mem_rdata;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios plus a randomized run against a cycle/transaction-level reference model.
// Memory is a behavioural array that only presents valid read data in the last access cycle.
module tb_mem_arb;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int L    = 2;
  localparam int SMAX = 3;

  logic          clk = 1'b0;
  logic          rst_f = 1'b1;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic          i_ack, d_ack, mem_en, mem_we, busy, owner;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_f(rst_f),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];

  // Reference model: one transaction at a time; grant at end of cycle N owns cycles N+1..N+L+1.
  int            cyc = 0;
  int            next_arb = 0;
  int            g_n = -1000;
  int            starve = 0;
  bit            g_own, g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata, g_val;
  logic [DW-1:0] exp_irdata = '0, exp_drdata = '0;

  task automatic model_sample();
    if (rst_f) begin
      g_n = -1000; next_arb = cyc + 1; starve = 0;
      exp_irdata = '0; exp_drdata = '0;
    end else if (cyc >= next_arb) begin
      if (i_req || d_req) begin
        g_own = d_req && !(i_req && starve == SMAX);
        if (g_own && i_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
        else starve = 0;
        g_n = cyc; next_arb = cyc + L + 2;
        g_we = g_own && d_we;
        g_addr = g_own ? d_addr : i_addr;
        g_wdata = g_own ? d_wdata : '0;
        if (g_we) ref_mem[g_addr[7:0]] = d_wdata;
        else g_val = ref_mem[g_addr[7:0]];
      end else begin
        starve = 0;
      end
    end
  endtask

  task automatic tick();
    model_sample();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == g_n + L + 1 && !g_we) begin
      if (g_own) exp_drdata = g_val; else exp_irdata = g_val;
    end
    if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
    mem_rdata = (cyc == g_n + L) ? mem[mem_addr[7:0]] : $urandom();
  endtask

  task automatic do_reset();
    rst_f = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick(); tick();
    rst_f = 1'b0;
  endtask

  task automatic test_reset();
    rst_f = 1'b1; i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) rst_f = 1'b0;
      tick();
      vectors++;
      if ({i_ack, d_ack, mem_en, mem_we, busy, owner} !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_ctrl k=%0d got=%b expected=000000", k, {i_ack, d_ack, mem_en, mem_we, busy, owner});
      end
      vectors++;
      if ({i_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
        miscompares++;
        $display("FAIL reset_data k=%0d got i_rdata=%h d_rdata=%h mem_addr=%h mem_wdata=%h expected all 0", k, i_rdata, d_rdata, mem_addr, mem_wdata);
      end
    end
  endtask

  task automatic test_single_fetch();
    int en_cnt = 0, ack_at = -1, d_seen = 0;
    logic [DW-1:0] got = '0;
    logic own = 1'b1;
    do_reset();
    mem[8'h10] = 32'h12345678; ref_mem[8'h10] = 32'h12345678;
    i_req = 1'b1; i_addr = 16'h0010;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (mem_en) begin
        en_cnt++;
        vectors++;
        if (mem_addr !== 16'h0010) begin
          miscompares++;
          $display("FAIL fetch_mem_addr got=%h expected=0010", mem_addr);
        end
      end
      if (d_ack) d_seen++;
      if (i_ack) begin ack_at = k; got = i_rdata; own = owner; i_req = 1'b0; end
    end
    vectors++;
    if (en_cnt !== L) begin miscompares++; $display("FAIL fetch_en_cycles got=%0d expected=%0d", en_cnt, L); end
    vectors++;
    if (ack_at !== L + 1) begin miscompares++; $display("FAIL fetch_ack_latency got=%0d expected=%0d", ack_at, L + 1); end
    vectors++;
    if (got !== 32'h12345678) begin miscompares++; $display("FAIL fetch_rdata got=%h expected=12345678", got); end
    vectors++;
    if (own !== 1'b0 || d_seen !== 0) begin miscompares++; $display("FAIL fetch_owner got owner=%b d_acks=%0d expected 0/0", own, d_seen); end
    vectors++;
    if (i_rdata !== 32'h12345678) begin miscompares++; $display("FAIL fetch_rdata_hold got=%h expected=12345678", i_rdata); end
  endtask

  task automatic test_store_load();
    int we_cnt = 0, ack_cnt = 0;
    logic [DW-1:0] got = '0;
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 32'hCAFEF00D;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (mem_we) begin
        we_cnt++;
        vectors++;
        if (mem_wdata !== 32'hCAFEF00D || mem_addr !== 16'h0020) begin
          miscompares++;
          $display("FAIL store_mem_bus got addr=%h wdata=%h expected 0020/cafef00d", mem_addr, mem_wdata);
        end
      end
      if (d_ack) begin ack_cnt++; d_req = 1'b0; d_wdata = 32'h0BAD0BAD; end
    end
    vectors++;
    if (we_cnt !== 1) begin miscompares++; $display("FAIL store_we_cycles got=%0d expected=1", we_cnt); end
    vectors++;
    if (ack_cnt !== 1) begin miscompares++; $display("FAIL store_ack_count got=%0d expected=1", ack_cnt); end
    vectors++;
    if (d_rdata !== '0) begin miscompares++; $display("FAIL store_drdata got=%h expected=0", d_rdata); end
    we_cnt = 0; ack_cnt = 0;
    d_req = 1'b1; d_we = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (mem_we) we_cnt++;
      if (d_ack) begin ack_cnt++; got = d_rdata; d_req = 1'b0; end
    end
    vectors++;
    if (we_cnt !== 0 || ack_cnt !== 1) begin miscompares++; $display("FAIL load_handshake got we=%0d acks=%0d expected 0/1", we_cnt, ack_cnt); end
    vectors++;
    if (got !== 32'hCAFEF00D) begin miscompares++; $display("FAIL load_rdata got=%h expected=cafef00d", got); end
  endtask

  task automatic test_simultaneous();
    int d_at = -1, i_at = -1, overlap = 0;
    do_reset();
    i_req = 1'b1; i_addr = 16'h0030; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (i_ack && d_ack) overlap++;
      if (d_ack && d_at < 0) begin d_at = k; d_req = 1'b0; end
      if (i_ack && i_at < 0) begin i_at = k; i_req = 1'b0; end
    end
    vectors++;
    if (d_at !== L + 1) begin miscompares++; $display("FAIL simul_data_first got d_ack at %0d expected %0d", d_at, L + 1); end
    vectors++;
    if (i_at !== d_at + L + 2) begin miscompares++; $display("FAIL simul_fetch_next got i_ack at %0d expected %0d", i_at, d_at + L + 2); end
    vectors++;
    if (overlap !== 0) begin miscompares++; $display("FAIL simul_overlap got=%0d expected=0", overlap); end
  endtask

  task automatic test_starvation();
    bit grants [8];
    int ng = 0, overlap = 0;
    do_reset();
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 16'h0001; d_addr = 16'h0002;
    for (int k = 0; k < 100 && ng < 8; k++) begin
      tick();
      if (i_ack && d_ack) overlap++;
      if (d_ack) begin grants[ng] = 1'b1; ng++; end
      else if (i_ack) begin grants[ng] = 1'b0; ng++; end
    end
    i_req = 1'b0; d_req = 1'b0;
    vectors++;
    if (ng !== 8) begin miscompares++; $display("FAIL starve_grant_count got=%0d expected=8", ng); end
    for (int k = 0; k < 8; k++) begin
      bit exp_d;
      exp_d = (k % (SMAX + 1)) != SMAX;
      vectors++;
      if (grants[k] !== exp_d) begin
        miscompares++;
        $display("FAIL starve_order grant=%0d got=%s expected=%s", k, grants[k] ? "D" : "I", exp_d ? "D" : "I");
      end
    end
    vectors++;
    if (overlap !== 0) begin miscompares++; $display("FAIL starve_overlap got=%0d expected=0", overlap); end
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_access();
    int ack_at = -1;
    logic [DW-1:0] got = '0;
    do_reset();
    mem[8'h50] = 32'hA5A50001; ref_mem[8'h50] = 32'hA5A50001;
    mem[8'h60] = 32'h600DF00D; ref_mem[8'h60] = 32'h600DF00D;
    i_req = 1'b1; i_addr = 16'h0050;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (i_ack) begin i_req = 1'b0; break; end
    end
    tick();
    i_req = 1'b1; i_addr = 16'h0060;
    tick(); tick();
    vectors++;
    if (mem_en !== 1'b1 || i_rdata !== 32'hA5A50001) begin
      miscompares++;
      $display("FAIL rstmid_precond got mem_en=%b i_rdata=%h expected 1/a5a50001", mem_en, i_rdata);
    end
    rst_f = 1'b1;
    tick();
    rst_f = 1'b0;
    vectors++;
    if ({i_ack, mem_en, mem_we, busy} !== 4'b0) begin
      miscompares++;
      $display("FAIL rstmid_ctrl got ack/en/we/busy=%b expected=0000", {i_ack, mem_en, mem_we, busy});
    end
    vectors++;
    if (i_rdata !== '0) begin miscompares++; $display("FAIL rstmid_irdata got=%h expected=0", i_rdata); end
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (i_ack) begin ack_at = k; got = i_rdata; i_req = 1'b0; break; end
    end
    vectors++;
    if (ack_at !== L + 1) begin miscompares++; $display("FAIL rstmid_refetch_latency got=%0d expected=%0d", ack_at, L + 1); end
    vectors++;
    if (got !== 32'h600DF00D) begin miscompares++; $display("FAIL rstmid_refetch_rdata got=%h expected=600df00d", got); end
  endtask

  task automatic test_random();
    bit e_acc, e_done, e_we;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (!i_req && $urandom_range(0, 2) == 0) i_req = 1'b1;
      if (!d_req && $urandom_range(0, 2) == 0) d_req = 1'b1;
      i_addr  = 16'($urandom_range(0, 65535));
      d_addr  = 16'($urandom_range(0, 65535));
      d_wdata = $urandom();
      d_we    = $urandom_range(0, 1) == 1;
      rst_f   = $urandom_range(0, 199) == 0;
      tick();
      e_acc  = (cyc >= g_n + 1) && (cyc <= g_n + L);
      e_done = (cyc == g_n + L + 1);
      e_we   = e_acc && (cyc == g_n + 1) && g_we;
      vectors++;
      if ({i_ack, d_ack} !== {e_done && !g_own, e_done && g_own}) begin
        miscompares++;
        $display("FAIL rnd_acks cyc=%0d got i/d=%b%b expected=%b%b", cyc, i_ack, d_ack, e_done && !g_own, e_done && g_own);
      end
      vectors++;
      if ({mem_en, mem_we, busy} !== {e_acc, e_we, e_acc || e_done}) begin
        miscompares++;
        $display("FAIL rnd_mem_ctrl cyc=%0d got en/we/busy=%b expected=%b", cyc, {mem_en, mem_we, busy}, {e_acc, e_we, e_acc || e_done});
      end
      vectors++;
      if (i_rdata !== exp_irdata || d_rdata !== exp_drdata) begin
        miscompares++;
        $display("FAIL rnd_rdata cyc=%0d got i=%h d=%h expected i=%h d=%h", cyc, i_rdata, d_rdata, exp_irdata, exp_drdata);
      end
      if (e_acc || e_done) begin
        vectors++;
        if (owner !== g_own || mem_addr !== g_addr) begin
          miscompares++;
          $display("FAIL rnd_owner_addr cyc=%0d got owner=%b addr=%h expected owner=%b addr=%h", cyc, owner, mem_addr, g_own, g_addr);
        end
      end
      if (e_we) begin
        vectors++;
        if (mem_wdata !== g_wdata) begin
          miscompares++;
          $display("FAIL rnd_wdata cyc=%0d got=%h expected=%h", cyc, mem_wdata, g_wdata);
        end
      end
      if (i_ack) i_req = $urandom_range(0, 3) == 0;
      if (d_ack) d_req = $urandom_range(0, 3) == 0;
    end
    rst_f = 1'b0; i_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
      ref_mem[i] = (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
    end
    test_reset();
    test_single_fetch();
    test_store_load();
    test_simultaneous();
    test_starvation();
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbiter and sequencer that shares one single-port unified 32-bit memory between the SISC instruction-fetch path (i_ port) and the load/store data path (d_ port).
- Sits between the pc/ir fetch logic and ctrl-driven load/store on one side, and the memory on the other.
- Latches each request and drives the memory for a fixed access latency, then returns read data with a one-cycle ack.
- Data requests have priority, with starvation protection for instruction fetch.

Parameters:
ADDR_W, 16, address width (matches pc_out width)
DATA_W, 32, data/instruction word width
MEM_LAT, 2, memory access cycles (legal 1..15); read data is valid in the last access cycle
STARVE_MAX, 3, consecutive data grants allowed while i_req is pending before fetch is forced

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_f  input  1  reset, synchronous, active-high
i_req  input  1  instruction fetch request, level, held until i_ack
i_addr  input  ADDR_W  fetch address
i_ack  output  1  one-cycle pulse, fetch complete, i_rdata valid
i_rdata  output  DATA_W  fetched word, registered, held until next fetch completes
d_req  input  1  data request, level, held until d_ack
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_ack  output  1  one-cycle pulse, data access complete
d_rdata  output  DATA_W  load data, registered, unchanged by stores
mem_en  output  1  memory enable, high for the whole access
mem_we  output  1  memory write strobe, first access cycle only
mem_addr  output  ADDR_W  latched address
mem_wdata  output  DATA_W  latched store data
mem_rdata  input  DATA_W  memory read data
busy  output  1  high in ACCESS and DONE
owner  output  1  0 = fetch, 1 = data; valid while busy

Behaviour:
- Clock is clk. Reset rst_f is synchronous and active-high.
- On reset:
  - State goes to IDLE.
  - All outputs go to 0, including i_rdata, d_rdata and mem_*.
  - starve_cnt and lat_cnt go to 0.
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise select an owner; latch the owner's addr, wdata and we; go to ACCESS with lat_cnt = MEM_LAT-1.
- Arbitration (evaluated in IDLE only):
  - d_req alone: data wins. i_req alone: fetch wins.
  - Both high: data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - starve_cnt increments (saturating at STARVE_MAX) on each data grant made while i_req is high.
  - starve_cnt clears on a fetch grant, or on any arbitration cycle with i_req low.
- ACCESS:
  - mem_en = 1 and mem_addr/mem_wdata are stable throughout.
  - mem_we = latched we only in the first ACCESS cycle.
  - lat_cnt decrements each cycle.
  - When lat_cnt == 0: if the access is a read, capture mem_rdata into the owner's rdata register; then go to DONE.
  - With MEM_LAT=1, ACCESS lasts exactly one cycle.
- DONE:
  - mem_en = 0.
  - Owner's ack = 1 for exactly one cycle; rdata is already valid.
  - Go to IDLE. Requests are not sampled in DONE.
- Latency: request first sampled in IDLE at cycle N -> ACCESS cycles N+1..N+MEM_LAT -> ack at N+MEM_LAT+1. Next arbitration is at N+MEM_LAT+2.
- Requester rules:
  - A requester must drop req in the cycle after its ack, unless it wants another access.
  - If req is still high in that IDLE cycle, a new transaction starts.
- Changes to i_addr, d_addr, d_wdata or d_we while busy are ignored; the latched values are used.
- Stores leave d_rdata unchanged. i_rdata changes only on fetch completion.
- Reset mid-ACCESS or mid-DONE: the access is abandoned, no ack is issued, mem_en/mem_we are 0 in the cycle after reset, and rdata registers are cleared.
- i_ack and d_ack are never high in the same cycle. At most one transaction is outstanding.

Test Plan:
- Reset then idle: rst_f=1 for 2 cycles, no requests -> all outputs 0, busy=0, mem_en never asserts.
- Single fetch, MEM_LAT=2: i_req=1, i_addr=0x0010, mem_rdata=0x12345678 during ACCESS -> mem_en high 2 cycles with mem_addr=0x0010; i_ack pulses 3 cycles after the req cycle; i_rdata=0x12345678; owner=0.
- Store then load: d_we=1, d_addr=0x0020, d_wdata=0xCAFEF00D -> mem_we high exactly 1 cycle, d_ack pulse, d_rdata stays 0. Then load from 0x0020 returning 0xCAFEF00D -> d_rdata=0xCAFEF00D.
- Starvation, STARVE_MAX=3: i_req and d_req held high continuously -> grant order D,D,D,I,D,D,D,I; no ack overlap.
- Simultaneous first request: both requests rise in the same cycle with starve_cnt=0 -> data is granted first; the fetch is granted immediately after the data d_ack.
- Reset mid-access: assert rst_f in the second ACCESS cycle of a fetch -> no i_ack; mem_en=0 next cycle; i_rdata=0; normal fetch afterwards completes with the same latency.
